pixel_write_sink: RTL and testbench

- Receiving end of the pixel-write stream that the game datapaths produce as valid/colour/coordinates, with a ready handshake added.
- Buffers incoming pixels in a small FIFO, clips any pixel outside the screen, converts {x,y} to a linear frame-buffer address (y*160+x), and issues one write per cycle to the 160x120x9 video memory.
- Also provides a full-screen clear that fills every frame-buffer location with one colour, run between game frames.

---
 rtl/pixel_write_sink_pkg.sv | 28 ++
 rtl/pixel_fifo.sv | 51 +++++
 rtl/pixel_write_sink.sv | 130 +++++++++++++
 tb/tb_pixel_write_sink.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_write_sink_pkg.sv
// rtl/pixel_write_sink_pkg.sv - shared constants, coordinate slices, state type and address helper
package pixel_write_sink_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int ADDR_W     = 15;
    localparam int COLOUR_W   = 9;
    localparam int COORD_W    = 15;
    localparam int FIFO_DEPTH = 4;
    localparam int FILL_LAST  = SCREEN_W * SCREEN_H - 1;

    localparam int X_MSB = 14;
    localparam int X_LSB = 7;
    localparam int Y_MSB = 6;
    localparam int Y_LSB = 0;

    typedef enum logic [1:0] {
        STREAM = 2'd0,
        DRAIN  = 2'd1,
        FILL   = 2'd2
    } sink_state_t;

    // y*160 + x as two shifted copies of y plus x, so no multiplier is needed
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO with occupancy counter, power-of-2 depth
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_write_sink.sv
// rtl/pixel_write_sink.sv - pixel stream sink: FIFO, clip, linear address, frame-buffer clear
module pixel_write_sink
    import pixel_write_sink_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [COLOUR_W-1:0] pix_colour,
    input  logic [COORD_W-1:0]  pix_coord,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                clear_done,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [COLOUR_W-1:0] mem_data,
    output logic                mem_wren,
    output logic [7:0]          drop_count
);

    localparam int ENTRY_W = COLOUR_W + COORD_W;

    sink_state_t state, state_next;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               accept;
    logic [ENTRY_W-1:0] fifo_dout;
    logic [7:0]         head_x;
    logic [6:0]         head_y;

    logic                s1_valid;
    logic                s1_in_range;
    logic [ADDR_W-1:0]   s1_addr;
    logic [COLOUR_W-1:0] s1_colour;

    logic [ADDR_W-1:0]   fill_cnt;
    logic [COLOUR_W-1:0] fill_colour;
    logic                fill_last;

    assign pix_ready = !fifo_full && (state == STREAM);
    assign accept    = pix_valid && pix_ready;
    assign fifo_pop  = !fifo_empty;
    assign head_x    = fifo_dout[X_MSB:X_LSB];
    assign head_y    = fifo_dout[Y_MSB:Y_LSB];
    assign fill_last = (fill_cnt == ADDR_W'(FILL_LAST));
    assign busy      = (state == DRAIN) || (state == FILL);

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (fifo_pop),
        .din   ({pix_colour, pix_coord}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_addr     <= '0;
            s1_colour   <= '0;
        end else begin
            s1_valid <= fifo_pop;
            if (fifo_pop) begin
                s1_addr     <= pixel_addr(head_x, head_y);
                s1_colour   <= fifo_dout[COORD_W +: COLOUR_W];
                s1_in_range <= (head_x < 8'(SCREEN_W)) && (head_y < 7'(SCREEN_H));
            end
        end
    end

    // A clipped pixel is counted in the slot where its write would have appeared
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (s1_valid && !s1_in_range && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STREAM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STREAM: if (clear_req) state_next = DRAIN;
            DRAIN:  if (fifo_empty && !s1_valid) state_next = FILL;
            FILL:   if (fill_last) state_next = STREAM;
            default: state_next = STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt    <= '0;
            fill_colour <= '0;
            clear_done  <= 1'b0;
        end else begin
            clear_done <= (state == FILL) && fill_last;
            if (state == STREAM && clear_req) fill_colour <= clear_colour;
            if (state == FILL) fill_cnt <= fill_last ? '0 : fill_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        mem_wren    = s1_valid && s1_in_range;
        mem_address = s1_addr;
        mem_data    = s1_colour;
        if (state == FILL) begin
            mem_wren    = 1'b1;
            mem_address = fill_cnt;
            mem_data    = fill_colour;
        end
    end

endmodule

// File: tb/tb_pixel_write_sink.sv
// tb/tb_pixel_write_sink.sv - directed self-checking bench for pixel_write_sink
module tb_pixel_write_sink;

    logic        clk;
    logic        reset;
    logic        pix_valid;
    logic        pix_ready;
    logic [8:0]  pix_colour;
    logic [14:0] pix_coord;
    logic        clear_req;
    logic [8:0]  clear_colour;
    logic        clear_done;
    logic        busy;
    logic [14:0] mem_address;
    logic [8:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    pixel_write_sink dut (
        .clk          (clk),
        .reset        (reset),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_colour   (pix_colour),
        .pix_coord    (pix_coord),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .busy         (busy),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] xy(input int x, input int y);
        logic [7:0] xs;
        logic [6:0] ys;
        xs = x[7:0];
        ys = y[6:0];
        return {xs, ys};
    endfunction

    initial begin
        int fill_writes;
        int addr_bad;
        int data_bad;
        int busy_bad;
        int ready_bad;
        int done_seen;
        int wren_seen;
        int found;

        reset = 1'b1;
        pix_valid = 1'b0;
        pix_colour = '0;
        pix_coord = '0;
        clear_req = 1'b0;
        clear_colour = '0;
        tick();
        tick();
        check("reset_pix_ready", pix_ready, 1);
        check("reset_mem_wren", mem_wren, 0);
        check("reset_busy", busy, 0);
        check("reset_clear_done", clear_done, 0);
        check("reset_drop_count", drop_count, 0);
        check("reset_mem_address", mem_address, 0);
        check("reset_mem_data", mem_data, 0);
        reset = 1'b0;
        tick();

        // single pixel (10,5): address 5*160+10 = 810, two cycles after accept
        pix_valid = 1'b1;
        pix_colour = 9'h1FF;
        pix_coord = xy(10, 5);
        tick();
        pix_valid = 1'b0;
        check("single_latency_n1_wren", mem_wren, 0);
        tick();
        check("single_wren", mem_wren, 1);
        check("single_addr", mem_address, 810);
        check("single_data", mem_data, 9'h1FF);
        check("single_drop", drop_count, 0);
        tick();

        // back-to-back corners
        pix_valid = 1'b1;
        pix_colour = 9'h011;
        pix_coord = xy(0, 0);
        check("b2b_ready0", pix_ready, 1);
        tick();
        pix_colour = 9'h022;
        pix_coord = xy(159, 119);
        check("b2b_ready1", pix_ready, 1);
        tick();
        pix_colour = 9'h033;
        pix_coord = xy(159, 0);
        check("b2b_ready2", pix_ready, 1);
        check("b2b_w0_wren", mem_wren, 1);
        check("b2b_w0_addr", mem_address, 0);
        tick();
        pix_valid = 1'b0;
        check("b2b_w1_wren", mem_wren, 1);
        check("b2b_w1_addr", mem_address, 19199);
        check("b2b_w1_data", mem_data, 9'h022);
        tick();
        check("b2b_w2_wren", mem_wren, 1);
        check("b2b_w2_addr", mem_address, 159);
        tick();
        check("b2b_idle_wren", mem_wren, 0);

        // clipping at x=160 and y=120
        pix_valid = 1'b1;
        pix_coord = xy(160, 0);
        tick();
        pix_coord = xy(0, 120);
        tick();
        pix_valid = 1'b0;
        check("clip_x_wren", mem_wren, 0);
        tick();
        check("clip_y_wren", mem_wren, 0);
        tick();
        check("clip_drop_count", drop_count, 2);

        pix_valid = 1'b1;
        pix_coord = xy(200, 10);
        for (int i = 0; i < 257; i++) tick();
        pix_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("clip_saturate", drop_count, 255);

        // clear with three pixels in flight
        pix_valid = 1'b1;
        pix_colour = 9'h001;
        pix_coord = xy(1, 1);
        tick();
        pix_colour = 9'h002;
        pix_coord = xy(2, 2);
        tick();
        pix_colour = 9'h003;
        pix_coord = xy(3, 3);
        clear_req = 1'b1;
        clear_colour = 9'h049;
        check("clr_p1_wren", mem_wren, 1);
        check("clr_p1_addr", mem_address, 161);
        tick();
        clear_req = 1'b0;
        clear_colour = 9'h000;
        pix_colour = 9'h0AA;
        pix_coord = xy(7, 0);
        check("clr_drain_busy", busy, 1);
        check("clr_drain_ready", pix_ready, 0);
        check("clr_p2_addr", mem_address, 322);
        check("clr_p2_wren", mem_wren, 1);
        tick();
        check("clr_p3_addr", mem_address, 483);
        check("clr_p3_data", mem_data, 9'h003);
        tick();

        fill_writes = 0;
        addr_bad = 0;
        data_bad = 0;
        busy_bad = 0;
        ready_bad = 0;
        for (int i = 0; i < 20000 && clear_done !== 1'b1; i++) begin
            if (mem_wren === 1'b1) begin
                if (mem_address !== 15'(fill_writes)) addr_bad++;
                if (mem_data !== 9'h049) data_bad++;
                fill_writes++;
            end
            if (busy !== 1'b1) busy_bad++;
            if (pix_ready !== 1'b0) ready_bad++;
            clear_req = (fill_writes == 100);
            clear_colour = 9'h1C0;
            tick();
        end
        clear_req = 1'b0;
        check("fill_write_count", fill_writes, 19200);
        check("fill_addr_errors", addr_bad, 0);
        check("fill_data_errors", data_bad, 0);
        check("fill_busy_errors", busy_bad, 0);
        check("fill_ready_errors", ready_bad, 0);
        check("fill_clear_done", clear_done, 1);
        check("done_busy", busy, 0);
        check("done_ready", pix_ready, 1);
        check("done_wren", mem_wren, 0);
        tick();
        pix_valid = 1'b0;
        check("done_pulse_width", clear_done, 0);
        tick();
        check("held_pix_wren", mem_wren, 1);
        check("held_pix_addr", mem_address, 7);
        check("held_pix_data", mem_data, 9'h0AA);

        done_seen = 0;
        busy_bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (clear_done === 1'b1) done_seen++;
            if (busy !== 1'b0) busy_bad++;
        end
        check("ignored_clear_done", done_seen, 0);
        check("ignored_clear_busy", busy_bad, 0);

        // reset in the middle of a fill
        clear_req = 1'b1;
        clear_colour = 9'h155;
        tick();
        clear_req = 1'b0;
        found = 0;
        for (int i = 0; i < 6000 && found == 0; i++) begin
            if (mem_wren === 1'b1 && mem_address === 15'd5000) begin
                found = 1;
            end else begin
                tick();
            end
        end
        check("rst_fill_reached_5000", found, 1);
        reset = 1'b1;
        tick();
        check("rst_wren", mem_wren, 0);
        check("rst_ready", pix_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_count, 0);
        check("rst_clear_done", clear_done, 0);
        reset = 1'b0;
        done_seen = 0;
        wren_seen = 0;
        for (int i = 0; i < 15000; i++) begin
            tick();
            if (clear_done === 1'b1) done_seen++;
            if (mem_wren === 1'b1) wren_seen++;
        end
        check("rst_no_clear_done", done_seen, 0);
        check("rst_no_writes", wren_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
